tap_ir_dr: RTL and testbench

//  JTAG instruction/data-register stage directly downstream of the TAP controller (TAP_route).

---
 rtl/tap_ir_dr.sv | 110 +++++++++++
 tb/tb_tap_ir_dr.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tap_ir_dr.sv
// tap_ir_dr: JTAG instruction / data register stage behind the TAP controller.
// It decodes the observed TAP state and captures, shifts and updates these registers:
//   - a 4-bit IR
//   - a 1-bit BYPASS register
//   - a 32-bit IDCODE register
//   - an 8-bit USER register
// Ports:
//   GCLK_Pad            clock, rising edge
//   TRST_Pad            async active-high reset
//   state_obs0..3_Pad   TAP state, bit0 is the LSB
//   TDI_Pad / TDO_Pad   serial data in and out. TDO is registered.
//   ir_q                active instruction
//   user_q              USER register parallel output
//   user_upd            1-cycle pulse after user_q is written
module tap_ir_dr #(
  parameter int          IR_W   = 4,
  parameter int          USER_W = 8,
  parameter logic [31:0] IDCODE = 32'h1A5C_0001
) (
  input  logic              GCLK_Pad,
  input  logic              TRST_Pad,
  input  logic              state_obs0_Pad,
  input  logic              state_obs1_Pad,
  input  logic              state_obs2_Pad,
  input  logic              state_obs3_Pad,
  input  logic              TDI_Pad,
  output logic              TDO_Pad,
  output logic [IR_W-1:0]   ir_q,
  output logic [USER_W-1:0] user_q,
  output logic              user_upd
);

  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } tap_state_t;

  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] OP_USER   = IR_W'(2);

  tap_state_t        s;
  logic [IR_W-1:0]   ir_sr;
  logic [31:0]       id_sr;
  logic [USER_W-1:0] usr_sr;
  logic [USER_W-1:0] usr_shift;
  logic              bp;
  logic              sel_id, sel_user;

  // All 16 codes are valid states, so the cast cannot produce an illegal value.
  assign s = tap_state_t'({state_obs3_Pad, state_obs2_Pad, state_obs1_Pad, state_obs0_Pad});

  // Any opcode other than IDCODE or USER selects BYPASS.
  assign sel_id   = (ir_q == OP_IDCODE);
  assign sel_user = (ir_q == OP_USER);

  // The shift is written with operators instead of a slice, so USER_W=1 still elaborates.
  assign usr_shift = (usr_sr >> 1) | (USER_W'(TDI_Pad) << (USER_W - 1));

  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      ir_sr    <= '0;
      ir_q     <= OP_IDCODE;
      id_sr    <= '0;
      usr_sr   <= '0;
      bp       <= 1'b0;
      user_q   <= '0;
      user_upd <= 1'b0;
      TDO_Pad  <= 1'b0;
    end else begin
      user_upd <= 1'b0;
      TDO_Pad  <= 1'b0;
      case (s)
        TLR:    ir_q  <= OP_IDCODE;
        CAP_IR: ir_sr <= IR_W'(1);
        SH_IR: begin
          TDO_Pad <= ir_sr[0];
          ir_sr   <= {TDI_Pad, ir_sr[IR_W-1:1]};
        end
        UPD_IR: ir_q <= ir_sr;
        CAP_DR: begin
          if (sel_user)    usr_sr <= user_q;
          else if (sel_id) id_sr  <= IDCODE;
          else             bp     <= 1'b0;
        end
        SH_DR: begin
          if (sel_user) begin
            TDO_Pad <= usr_sr[0];
            usr_sr  <= usr_shift;
          end else if (sel_id) begin
            TDO_Pad <= id_sr[0];
            id_sr   <= {TDI_Pad, id_sr[31:1]};
          end else begin
            TDO_Pad <= bp;
            bp      <= TDI_Pad;
          end
        end
        UPD_DR: begin
          if (sel_user) begin
            user_q   <= usr_sr;
            user_upd <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_ir_dr.sv
// tb_tap_ir_dr: directed test of tap_ir_dr.
// The bench drives TAP states directly and checks the serial and parallel outputs
// against hand-computed expected values.
module tb_tap_ir_dr;

  localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, CAP_DR = 4'h6, SH_DR = 4'h2,
                         EX1_DR = 4'h1, UPD_DR = 4'h5, CAP_IR = 4'hE,
                         SH_IR = 4'hA, EX1_IR = 4'h9, UPD_IR = 4'hD;

  logic       clk, rst, tdi, tdo, user_upd;
  logic [3:0] st, ir_q;
  logic [7:0] user_q;
  logic [63:0] outs;
  int total, bad;

  tap_ir_dr dut (
    .GCLK_Pad(clk), .TRST_Pad(rst),
    .state_obs0_Pad(st[0]), .state_obs1_Pad(st[1]),
    .state_obs2_Pad(st[2]), .state_obs3_Pad(st[3]),
    .TDI_Pad(tdi), .TDO_Pad(tdo),
    .ir_q(ir_q), .user_q(user_q), .user_upd(user_upd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time limit reached, required summary before limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one state and TDI, then clock once. Outputs are sampled 1ns after the edge.
  task automatic tick(input logic [3:0] s, input logic t);
    st = s;
    tdi = t;
    @(posedge clk);
    #1;
  endtask

  // Run n shift cycles in state s, feeding bits LSB-first, and collect the TDO stream.
  task automatic shift(input logic [3:0] s, input int n, input logic [63:0] bits,
                       output logic [63:0] o);
    o = '0;
    for (int i = 0; i < n; i++) begin
      tick(s, bits[i]);
      o[i] = tdo;
    end
  endtask

  task automatic load_ir(input logic [3:0] op);
    tick(CAP_IR, 1'b0);
    shift(SH_IR, 4, {60'd0, op}, outs);
    tick(EX1_IR, 1'b0);
    tick(UPD_IR, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; st = TLR; tdi = 1'b0;

    // T1: reset values must be visible before the first clock edge.
    #2;
    chk("rst_ir", 64'(ir_q), 64'h1);
    chk("rst_user", 64'(user_q), 64'h0);
    chk("rst_tdo", 64'(tdo), 64'h0);
    chk("rst_upd", 64'(user_upd), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(RTI, 1'b0);

    // T2: read IDCODE.
    tick(CAP_DR, 1'b0);
    shift(SH_DR, 32, 64'd0, outs);
    chk("id_first", 64'(outs[0]), 64'h1);
    chk("id_stream", outs, 64'h1A5C_0001);
    tick(EX1_DR, 1'b0);
    chk("id_tdo_idle", 64'(tdo), 64'h0);
    tick(UPD_DR, 1'b0);
    chk("id_no_upd", 64'(user_upd), 64'h0);
    tick(RTI, 1'b0);

    // T3: load the USER opcode into the IR.
    tick(CAP_IR, 1'b0);
    shift(SH_IR, 4, 64'b0010, outs);
    chk("ir_stream", outs, 64'b0001);
    tick(EX1_IR, 1'b0);
    chk("ir_hold", 64'(ir_q), 64'h1);
    tick(UPD_IR, 1'b0);
    chk("ir_user", 64'(ir_q), 64'h2);

    // T4: write A5 to USER.
    tick(CAP_DR, 1'b0);
    shift(SH_DR, 8, 64'hA5, outs);
    chk("usr_out0", outs, 64'h0);
    tick(EX1_DR, 1'b0);
    chk("usr_pre_upd", 64'(user_q), 64'h0);
    tick(UPD_DR, 1'b0);
    chk("usr_q", 64'(user_q), 64'hA5);
    chk("usr_upd_hi", 64'(user_upd), 64'h1);
    tick(RTI, 1'b0);
    chk("usr_upd_lo", 64'(user_upd), 64'h0);

    // Zero shift cycles: the captured value is written back unchanged.
    tick(CAP_DR, 1'b0);
    tick(EX1_DR, 1'b0);
    tick(UPD_DR, 1'b0);
    chk("zero_sh_q", 64'(user_q), 64'hA5);
    chk("zero_sh_upd", 64'(user_upd), 64'h1);

    // Read back with TDI=0. The update then writes 00.
    tick(CAP_DR, 1'b0);
    shift(SH_DR, 8, 64'd0, outs);
    chk("usr_read", outs, 64'hA5);
    tick(EX1_DR, 1'b0);
    tick(UPD_DR, 1'b0);
    chk("usr_clr", 64'(user_q), 64'h0);

    // Over-long shift of 10 bits: 1,1 then 3C LSB-first. Only the last 8 bits survive.
    // TDO shows the 8 captured zeros, then the two leading ones.
    tick(CAP_DR, 1'b0);
    shift(SH_DR, 10, 64'h0F3, outs);
    chk("long_stream", outs, 64'h300);
    tick(EX1_DR, 1'b0);
    tick(UPD_DR, 1'b0);
    chk("long_q", 64'(user_q), 64'h3C);

    // T5: an unknown opcode (7) acts as BYPASS.
    load_ir(4'h7);
    chk("ir_7", 64'(ir_q), 64'h7);
    tick(CAP_DR, 1'b0);
    shift(SH_DR, 3, 64'b101, outs);
    chk("byp_stream", outs, 64'b010);
    tick(EX1_DR, 1'b0);
    tick(UPD_DR, 1'b0);
    chk("byp_user_q", 64'(user_q), 64'h3C);
    chk("byp_no_upd", 64'(user_upd), 64'h0);

    // T6: assert reset in the 4th USER shift cycle (USER holds 3C, so TDO is 1 beforehand).
    load_ir(4'h2);
    tick(CAP_DR, 1'b0);
    shift(SH_DR, 3, 64'b111, outs);
    chk("pre_rst_tdo", 64'(tdo), 64'h1);
    st = SH_DR; tdi = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ir", 64'(ir_q), 64'h1);
    chk("mid_rst_user", 64'(user_q), 64'h0);
    chk("mid_rst_tdo", 64'(tdo), 64'h0);
    chk("mid_rst_upd", 64'(user_upd), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(EX1_DR, 1'b0);
    tick(UPD_DR, 1'b0);
    chk("post_rst_upd", 64'(user_upd), 64'h0);
    chk("post_rst_user", 64'(user_q), 64'h0);

    // Test-Logic-Reset forces the IDCODE opcode on the next edge.
    load_ir(4'h2);
    chk("pre_tlr_ir", 64'(ir_q), 64'h2);
    tick(TLR, 1'b0);
    chk("tlr_ir", 64'(ir_q), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
